// File: rtl/layer_out_serializer.sv
// -----------------------------------------------------------------------------
// layer_out_serializer
//
// Sits between two layer instances. Collects the NN per-neuron results of the
// producing layer (each neuron may finish on its own cycle, in any order) and
// streams them one word per cycle, neuron 0 first, into the serial input of
// the next layer. A collect buffer and a shift buffer are kept separately so
// the producing layer can fill its next vector while the previous one is
// still being streamed out. Back-to-back vectors stream without a gap.
//
// State table:
//   IDLE  | shift buffer empty; x_valid/busy low, x_in holds its last word
//   SHIFT | streaming sh_data word[count]; x_valid/busy high
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   o_valid   in   [NN]            per-neuron result-valid pulses
//   x_out     in   [NN*dataWidth]  neuron i at [i*dataWidth +: dataWidth]
//   x_valid   out                  serial word valid (registered)
//   x_in      out  [dataWidth]     serial word (registered)
//   busy      out                  high while the shift buffer is streaming
//   overflow  out                  sticky: a neuron result was dropped
// -----------------------------------------------------------------------------
module layer_out_serializer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           o_valid,
    input  logic [NN*dataWidth-1:0] x_out,
    output logic                    x_valid,
    output logic [dataWidth-1:0]    x_in,
    output logic                    busy,
    output logic                    overflow
);

    localparam int CW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [CW-1:0] LAST = CW'(NN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          count, count_next, count_inc;
    logic [dataWidth-1:0]   col_data [NN];
    logic [dataWidth-1:0]   sh_data  [NN];
    logic [NN-1:0]          col_flags, col_flags_next, col_held, capture;
    logic                   overflow_next;
    logic                   transfer;
    logic                   x_valid_next, busy_next;
    logic [dataWidth-1:0]   x_in_next;

    // The shifter can accept a new vector when idle, or on the edge that
    // retires its last word, which is what makes back-to-back streaming gapless.
    assign transfer = (&col_flags) &&
                      ((state == IDLE) || ((state == SHIFT) && (count == LAST)));

    assign count_inc = count + CW'(1);

    // ---------------------------------------------------------------- collect
    // Flags being handed to the shifter this edge count as already cleared, so
    // a neuron reporting on the transfer edge starts the next vector instead
    // of being flagged as a duplicate.
    always_comb begin
        col_held       = transfer ? '0 : col_flags;
        capture        = o_valid & ~col_held;
        col_flags_next = col_held | o_valid;
        overflow_next  = overflow | (|(o_valid & col_held));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_flags <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < NN; i++) begin
                col_data[i] <= '0;
            end
        end else begin
            col_flags <= col_flags_next;
            overflow  <= overflow_next;
            for (int i = 0; i < NN; i++) begin
                if (capture[i]) begin
                    col_data[i] <= x_out[i*dataWidth +: dataWidth];
                end
            end
        end
    end

    // ---------------------------------------------------------------- shift buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NN; i++) begin
                sh_data[i] <= '0;
            end
        end else if (transfer) begin
            for (int i = 0; i < NN; i++) begin
                sh_data[i] <= col_data[i];
            end
        end
    end

    // ---------------------------------------------------------------- shift FSM
    // x_in is registered, so on a transfer the first word is taken straight
    // from the collect buffer (sh_data is only loaded on that same edge).
    always_comb begin
        state_next   = state;
        count_next   = count;
        x_valid_next = x_valid;
        busy_next    = busy;
        x_in_next    = x_in;
        case (state)
            IDLE: begin
                x_valid_next = 1'b0;
                busy_next    = 1'b0;
                if (transfer) begin
                    state_next   = SHIFT;
                    count_next   = '0;
                    x_valid_next = 1'b1;
                    busy_next    = 1'b1;
                    x_in_next    = col_data[0];
                end
            end
            SHIFT: begin
                x_valid_next = 1'b1;
                busy_next    = 1'b1;
                if (count == LAST) begin
                    if (transfer) begin
                        count_next = '0;
                        x_in_next  = col_data[0];
                    end else begin
                        state_next   = IDLE;
                        count_next   = '0;
                        x_valid_next = 1'b0;
                        busy_next    = 1'b0;
                    end
                end else begin
                    count_next = count_inc;
                    x_in_next  = sh_data[count_inc];
                end
            end
            default: begin
                state_next   = IDLE;
                count_next   = '0;
                x_valid_next = 1'b0;
                busy_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            x_in    <= '0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            x_valid <= x_valid_next;
            busy    <= busy_next;
            x_in    <= x_in_next;
        end
    end

endmodule

// File: tb/tb_layer_out_serializer.sv
// -----------------------------------------------------------------------------
// Bench for layer_out_serializer (NN=4, dataWidth=16).
// The reference model works at vector level: it tracks which neuron slots of
// the next vector are filled, when the shifter becomes free, and schedules the
// expected serial words on an absolute cycle timeline.
// -----------------------------------------------------------------------------
module tb_layer_out_serializer;

    localparam int NN    = 4;
    localparam int DW    = 16;
    localparam int TLEN  = 4096;

    logic               clk;
    logic               rst;
    logic [NN-1:0]      o_valid;
    logic [NN*DW-1:0]   x_out;
    logic               x_valid;
    logic [DW-1:0]      x_in;
    logic               busy;
    logic               overflow;

    layer_out_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .o_valid  (o_valid),
        .x_out    (x_out),
        .x_valid  (x_valid),
        .x_in     (x_in),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    int              cyc;
    logic            exp_v [TLEN];
    logic [DW-1:0]   exp_w [TLEN];
    logic [NN-1:0]   m_flags;
    logic [DW-1:0]   m_data [NN];
    int              m_free;
    logic            m_ovf;
    logic [DW-1:0]   m_last;
    logic            rst_drive;

    int n_vec;
    int n_err;

    task automatic model_reset();
        m_flags = '0;
        m_ovf   = 1'b0;
        m_free  = 0;
        m_last  = '0;
        for (int j = cyc; j < TLEN; j++) exp_v[j] = 1'b0;
    endtask

    // Effect of the clock edge numbered cyc.
    task automatic model_edge(input logic [NN-1:0] ov, input logic [NN*DW-1:0] xo);
        if (!rst) begin
            if ((&m_flags) && (cyc >= m_free)) begin
                for (int k = 0; k < NN; k++) begin
                    exp_v[cyc + k] = 1'b1;
                    exp_w[cyc + k] = m_data[k];
                end
                m_flags = '0;
                m_free  = cyc + NN;
            end
            for (int i = 0; i < NN; i++) begin
                if (ov[i]) begin
                    if (m_flags[i]) m_ovf = 1'b1;
                    else begin
                        m_flags[i] = 1'b1;
                        m_data[i]  = xo[i*DW +: DW];
                    end
                end
            end
            if (exp_v[cyc]) m_last = exp_w[cyc];
        end
    endtask

    task automatic check_outputs();
        n_vec++;
        assert (x_valid === exp_v[cyc]) else begin
            n_err++;
            $error("FAIL x_valid cyc=%0d got=%b exp=%b", cyc, x_valid, exp_v[cyc]);
        end
        n_vec++;
        assert (busy === exp_v[cyc]) else begin
            n_err++;
            $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_v[cyc]);
        end
        n_vec++;
        assert (x_in === m_last) else begin
            n_err++;
            $error("FAIL x_in cyc=%0d got=%h exp=%h", cyc, x_in, m_last);
        end
        n_vec++;
        assert (overflow === m_ovf) else begin
            n_err++;
            $error("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
        end
    endtask

    task automatic step(input logic [NN-1:0] ov, input logic [NN*DW-1:0] xo);
        @(negedge clk);
        rst     = rst_drive;
        o_valid = ov;
        x_out   = xo;
        @(posedge clk);
        cyc++;
        model_edge(ov, xo);
        #1;
        check_outputs();
        o_valid = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0);
    endtask

    initial begin
        logic [NN-1:0] ov;
        n_vec     = 0;
        n_err     = 0;
        cyc       = 0;
        rst       = 1'b1;
        rst_drive = 1'b1;
        o_valid   = '0;
        x_out     = '0;
        for (int j = 0; j < TLEN; j++) begin
            exp_v[j] = 1'b0;
            exp_w[j] = '0;
        end
        for (int i = 0; i < NN; i++) m_data[i] = '0;
        model_reset();

        // reset state
        #2;
        check_outputs();
        step('0, '0);
        step('0, '0);
        rst_drive = 1'b0;
        idle(2);

        // single simultaneous vector
        step(4'hF, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
        idle(8);

        // staggered arrival: bits 2,0,3,1 at cycles 0,3,4,9
        for (int c = 0; c < 10; c++) begin
            ov = (c == 0) ? 4'b0100 : (c == 3) ? 4'b0001 :
                 (c == 4) ? 4'b1000 : (c == 9) ? 4'b0010 : 4'b0000;
            step(ov, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0});
        end
        idle(8);

        // back-to-back vectors
        step(4'hF, {16'h0C03, 16'h0C02, 16'h0C01, 16'h0C00});
        step('0, '0);
        step(4'hF, {16'h0B03, 16'h0B02, 16'h0B01, 16'h0B00});
        idle(12);

        // overflow while collect full and shifter busy
        step(4'hF, {16'h0D03, 16'h0D02, 16'h0D01, 16'h0D00});
        step('0, '0);
        step(4'hF, {16'h0E03, 16'h0E02, 16'h0E01, 16'h0E00});
        step(4'b0010, {16'h0000, 16'h0000, 16'hFFFF, 16'h0000});
        idle(12);

        // capture on the transfer edge
        step(4'hF, {16'h0F03, 16'h0F02, 16'h0F01, 16'h0F00});
        step(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0777});
        step(4'b1110, {16'h1003, 16'h1002, 16'h1001, 16'h0000});
        idle(12);

        // async reset mid-stream, after two of four words
        step(4'hF, {16'h2003, 16'h2002, 16'h2001, 16'h2000});
        step('0, '0);
        step('0, '0);
        #1;
        rst       = 1'b1;
        rst_drive = 1'b1;
        model_reset();
        #1;
        check_outputs();
        step('0, '0);
        step('0, '0);
        rst_drive = 1'b0;
        idle(8);
        step(4'hF, {16'h3003, 16'h3002, 16'h3001, 16'h3000});
        idle(8);

        // randomized traffic
        for (int r = 0; r < 500; r++) begin
            ov = '0;
            for (int i = 0; i < NN; i++) ov[i] = ($urandom_range(0, 3) == 0);
            if ((r % 100) > 80) ov = '0;
            step(ov, {$urandom, $urandom});
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
